i2s_tdm_transmitter: RTL and testbench

//  Parametrised I2S/TDM serialiser for the DAC path. BClk and LRClk come from the codec and are

---
 rtl/i2s_tdm_transmitter.sv | 170 +++++++++++++++++
 tb/tb_i2s_tdm_transmitter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tdm_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : i2s_tdm_transmitter
// Brief    : I2S / left-justified / right-justified / TDM serialiser clocked by
//            codec BClk and LRClk, both oversampled on Clk.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_tdm_transmitter #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int SLOT_WIDTH   = 32,
    parameter int CHANNELS     = 2
) (
    input  logic                             Clk,
    input  logic                             RstN,
    input  logic                             BClk,
    input  logic                             LRClk,
    input  logic [1:0]                       Mode,
    input  logic [CHANNELS*SAMPLE_WIDTH-1:0] SampleIn,
    input  logic                             SampleValid,
    output logic                             SampleReady,
    output logic                             DacDat,
    output logic                             Underrun,
    output logic                             FrameErr
);

    localparam int c_frame_bits = CHANNELS * SLOT_WIDTH;
    localparam int c_cnt_w      = $clog2(c_frame_bits + 1);
    localparam int c_ch_w       = $clog2(CHANNELS);
    localparam int c_sbit_w     = $clog2(SAMPLE_WIDTH);
    localparam int c_word_w     = CHANNELS * SAMPLE_WIDTH;

    localparam logic [c_cnt_w-1:0] c_cnt_frame  = c_cnt_w'(c_frame_bits);
    localparam logic [c_cnt_w-1:0] c_cnt_last   = c_cnt_w'(c_frame_bits - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_slot   = c_cnt_w'(SLOT_WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_sample = c_cnt_w'(SAMPLE_WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_smsb   = c_cnt_w'(SAMPLE_WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_rj     = c_cnt_w'(SLOT_WIDTH - SAMPLE_WIDTH);
    localparam logic               c_wrap_en    = (SAMPLE_WIDTH == SLOT_WIDTH);
    localparam logic [1:0]         c_mode_i2s   = 2'd0;
    localparam logic [1:0]         c_mode_rj    = 2'd2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                r_state;
    logic [2:0]            r_bclk_sync;
    logic [2:0]            r_lrclk_sync;
    logic [c_word_w-1:0]   r_hold;
    logic                  r_hold_valid;
    logic [c_word_w-1:0]   r_active;
    logic [1:0]            r_mode;
    logic [c_cnt_w-1:0]    r_frame_bit;
    logic                  r_prev_lsb;

    logic                  w_bfall;
    logic                  w_fstart;
    logic                  w_accept;
    logic                  w_frame_err;
    logic [c_cnt_w-1:0]    w_fb_next;
    logic [c_word_w-1:0]   w_active_next;
    logic [1:0]            w_mode_next;
    logic                  w_prev_next;
    logic [c_cnt_w-1:0]    w_offset;
    logic [c_cnt_w-1:0]    w_q;
    logic [c_cnt_w-1:0]    w_pos;
    logic [c_ch_w-1:0]     w_slot;
    logic [c_sbit_w-1:0]   w_bit;
    logic                  w_dat_next;
    logic [SAMPLE_WIDTH-1:0] w_words [CHANNELS];

    // Index [1] is the synchronised level, [2] its previous value.
    assign w_bfall     = r_bclk_sync[2] & ~r_bclk_sync[1];
    assign w_fstart    = r_lrclk_sync[2] & ~r_lrclk_sync[1];
    assign w_accept    = SampleValid & ~r_hold_valid;
    assign SampleReady = ~r_hold_valid;
    assign w_frame_err = w_fstart && (r_state == ST_RUN) &&
                         (r_frame_bit != '0) && (r_frame_bit < c_cnt_last);

    // Values as they will be after this edge; DacDat is derived from them.
    always_comb begin
        w_fb_next = r_frame_bit;
        if (w_fstart) begin
            w_fb_next = '0;
        end else if (w_bfall && (r_frame_bit != c_cnt_frame)) begin
            w_fb_next = r_frame_bit + c_cnt_one;
        end
    end

    assign w_active_next = w_fstart ? (r_hold_valid ? r_hold : '0) : r_active;
    assign w_mode_next   = w_fstart ? Mode : r_mode;
    assign w_prev_next   = w_fstart ? r_active[(CHANNELS-1)*SAMPLE_WIDTH] : r_prev_lsb;

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_words
        assign w_words[ch] = w_active_next[ch*SAMPLE_WIDTH +: SAMPLE_WIDTH];
    end

    always_comb begin
        w_offset = '0;
        if (w_mode_next == c_mode_i2s) begin
            w_offset = c_cnt_one;
        end else if (w_mode_next == c_mode_rj) begin
            w_offset = c_cnt_rj;
        end
        w_q        = w_fb_next - w_offset;
        w_pos      = w_q % c_cnt_slot;
        w_slot     = c_ch_w'(w_q / c_cnt_slot);
        w_bit      = c_sbit_w'(c_cnt_smsb - w_pos);
        w_dat_next = 1'b0;
        if (w_fb_next != c_cnt_frame) begin
            // I2S bit 0 carries the tail of the previous frame's last channel.
            if ((w_mode_next == c_mode_i2s) && (w_fb_next == '0)) begin
                w_dat_next = c_wrap_en & w_prev_next;
            end else if ((w_fb_next >= w_offset) && (w_pos < c_cnt_sample)) begin
                w_dat_next = w_words[w_slot][w_bit];
            end
        end
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            r_state      <= ST_IDLE;
            r_bclk_sync  <= '0;
            r_lrclk_sync <= '0;
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_active     <= '0;
            r_mode       <= '0;
            r_frame_bit  <= '0;
            r_prev_lsb   <= 1'b0;
            DacDat       <= 1'b0;
            Underrun     <= 1'b0;
            FrameErr     <= 1'b0;
        end else begin
            r_bclk_sync  <= {r_bclk_sync[1:0], BClk};
            r_lrclk_sync <= {r_lrclk_sync[1:0], LRClk};
            Underrun     <= 1'b0;
            FrameErr     <= 1'b0;

            // A word accepted on the frame-start cycle lands in hold for the next frame.
            if (w_fstart && r_hold_valid) begin
                r_hold_valid <= 1'b0;
            end else if (w_accept) begin
                r_hold       <= SampleIn;
                r_hold_valid <= 1'b1;
            end

            if ((r_state == ST_IDLE) && w_fstart) begin
                r_state <= ST_RUN;
            end

            if (w_fstart) begin
                r_mode     <= Mode;
                r_active   <= w_active_next;
                r_prev_lsb <= w_prev_next;
                Underrun   <= ~r_hold_valid;
                FrameErr   <= w_frame_err;
            end

            if (w_fstart || (w_bfall && (r_state == ST_RUN))) begin
                r_frame_bit <= w_fb_next;
                DacDat      <= w_dat_next;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2s_tdm_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_tdm_transmitter
// Brief    : Directed scoreboard bench for i2s_tdm_transmitter in four configs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_tdm_transmitter;

    logic        Clk = 1'b0;
    logic        RstN;
    logic        BClk;
    logic        LRClk;
    logic [1:0]  Mode;
    logic [31:0] din_a;
    logic [47:0] din_b;
    logic [63:0] din_c;
    logic [31:0] din_d;
    logic [3:0]  vld;
    wire  [3:0]  rdy;
    wire  [3:0]  dat;
    wire  [3:0]  ur;
    wire  [3:0]  fe;

    int   total = 0;
    int   bad   = 0;
    int   ur_cnt [4];
    int   fe_cnt [4];
    int   ur_base;
    int   fe_base;
    logic exp_q [$];

    always #5 Clk = ~Clk;

    i2s_tdm_transmitter #(.SAMPLE_WIDTH(16), .SLOT_WIDTH(16), .CHANNELS(2)) u_a (
        .Clk(Clk), .RstN(RstN), .BClk(BClk), .LRClk(LRClk), .Mode(Mode),
        .SampleIn(din_a), .SampleValid(vld[0]), .SampleReady(rdy[0]),
        .DacDat(dat[0]), .Underrun(ur[0]), .FrameErr(fe[0]));

    i2s_tdm_transmitter #(.SAMPLE_WIDTH(24), .SLOT_WIDTH(32), .CHANNELS(2)) u_b (
        .Clk(Clk), .RstN(RstN), .BClk(BClk), .LRClk(LRClk), .Mode(Mode),
        .SampleIn(din_b), .SampleValid(vld[1]), .SampleReady(rdy[1]),
        .DacDat(dat[1]), .Underrun(ur[1]), .FrameErr(fe[1]));

    i2s_tdm_transmitter #(.SAMPLE_WIDTH(16), .SLOT_WIDTH(32), .CHANNELS(4)) u_c (
        .Clk(Clk), .RstN(RstN), .BClk(BClk), .LRClk(LRClk), .Mode(Mode),
        .SampleIn(din_c), .SampleValid(vld[2]), .SampleReady(rdy[2]),
        .DacDat(dat[2]), .Underrun(ur[2]), .FrameErr(fe[2]));

    i2s_tdm_transmitter #(.SAMPLE_WIDTH(16), .SLOT_WIDTH(32), .CHANNELS(2)) u_d (
        .Clk(Clk), .RstN(RstN), .BClk(BClk), .LRClk(LRClk), .Mode(Mode),
        .SampleIn(din_d), .SampleValid(vld[3]), .SampleReady(rdy[3]),
        .DacDat(dat[3]), .Underrun(ur[3]), .FrameErr(fe[3]));

    always @(negedge Clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ur[i]) ur_cnt[i]++;
            if (fe[i]) fe_cnt[i]++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected serial stream: slots concatenated, sample placed left or right, I2S delayed one bit.
    task automatic push_frame(input int sw, input int slot, input int ch, input logic [127:0] w,
                              input int mode, input logic prev, input int nbits);
        logic s [$];
        s = {};
        if (mode == 0) s.push_back((sw == slot) ? prev : 1'b0);
        for (int c = 0; c < ch; c++) begin
            if (mode == 2) for (int i = 0; i < slot - sw; i++) s.push_back(1'b0);
            for (int i = sw - 1; i >= 0; i--) s.push_back(w[c*sw + i]);
            if (mode != 2) for (int i = 0; i < slot - sw; i++) s.push_back(1'b0);
        end
        for (int b = 0; b < nbits; b++) exp_q.push_back((b < ch*slot) ? s[b] : 1'b0);
    endtask

    task automatic run_frame(input int nbits, input int tgt, input int mid_mode);
        logic e;
        for (int b = 0; b < nbits; b++) begin
            BClk = 1'b1;
            repeat (4) @(negedge Clk);
            BClk = 1'b0;
            if (b == 0) LRClk = 1'b0;
            if (b == nbits/2) begin
                LRClk = 1'b1;
                if (mid_mode >= 0) Mode = mid_mode[1:0];
            end
            repeat (4) @(negedge Clk);
            e = exp_q.pop_front();
            check($sformatf("dat%0d_bit%0d", tgt, b), {31'd0, dat[tgt]}, {31'd0, e});
        end
    endtask

    task automatic offer(input int idx, input logic [127:0] w);
        @(negedge Clk);
        check($sformatf("ready%0d_before", idx), {31'd0, rdy[idx]}, 32'd1);
        case (idx)
            0:       din_a = w[31:0];
            1:       din_b = w[47:0];
            2:       din_c = w[63:0];
            default: din_d = w[31:0];
        endcase
        vld[idx] = 1'b1;
        @(negedge Clk);
        vld[idx] = 1'b0;
        check($sformatf("ready%0d_after", idx), {31'd0, rdy[idx]}, 32'd0);
        din_a = ~din_a;
        din_b = ~din_b;
        din_c = ~din_c;
        din_d = ~din_d;
    endtask

    initial begin
        RstN  = 1'b0;
        BClk  = 1'b1;
        LRClk = 1'b1;
        Mode  = 2'd0;
        vld   = '0;
        din_a = '0;
        din_b = '0;
        din_c = '0;
        din_d = '0;

        // Reset state
        repeat (3) @(negedge Clk);
        check("rst_dat", {28'd0, dat}, 32'd0);
        check("rst_ur",  {28'd0, ur},  32'd0);
        check("rst_fe",  {28'd0, fe},  32'd0);
        RstN = 1'b1;
        @(negedge Clk);
        check("ready_after_rst", {28'd0, rdy}, 32'hF);

        // I2S 16/16 stereo with wrap of the right-channel LSB
        Mode = 2'd0;
        offer(0, 128'h0F0F_A5F0);
        push_frame(16, 16, 2, 128'h0F0F_A5F0, 0, 1'b0, 32);
        run_frame(32, 0, -1);
        check("i2s_no_underrun", ur_cnt[0], 0);
        offer(0, 128'h8001_1234);
        push_frame(16, 16, 2, 128'h8001_1234, 0, 1'b1, 32);
        run_frame(32, 0, -1);
        push_frame(16, 16, 2, 128'h0, 0, 1'b1, 32);
        run_frame(32, 0, -1);
        check("i2s_underrun", ur_cnt[0], 1);

        // Reset mid-frame with a word waiting in hold
        Mode = 2'd1;
        offer(0, 128'hFFFF_FFFF);
        push_frame(16, 16, 2, 128'hFFFF_FFFF, 1, 1'b0, 5);
        run_frame(5, 0, -1);
        offer(0, 128'h1357_2468);
        ur_base = ur_cnt[0];
        #3 RstN = 1'b0;
        #1 check("rst_async_dat", {31'd0, dat[0]}, 32'd0);
        repeat (2) @(negedge Clk);
        RstN = 1'b1;
        @(negedge Clk);
        check("rst_ready", {31'd0, rdy[0]}, 32'd1);
        check("rst_no_pulse", {30'd0, ur[0], fe[0]}, 32'd0);
        push_frame(16, 16, 2, 128'h0, 1, 1'b0, 32);
        run_frame(32, 0, -1);
        check("rst_hold_discarded", ur_cnt[0] - ur_base, 1);

        // RJ then LJ, 24-bit samples in 32-bit slots; mid-frame Mode change ignored
        Mode = 2'd2;
        offer(1, 128'h5A5A5A_800001);
        push_frame(24, 32, 2, 128'h5A5A5A_800001, 2, 1'b0, 64);
        run_frame(64, 1, 0);
        Mode = 2'd1;
        offer(1, 128'h5A5A5A_800001);
        push_frame(24, 32, 2, 128'h5A5A5A_800001, 1, 1'b0, 64);
        run_frame(64, 1, -1);

        // TDM, four channels, Mode 3 behaves as left-justified
        Mode = 2'd3;
        offer(2, 128'h4444_3333_2222_1111);
        push_frame(16, 32, 4, 128'h4444_3333_2222_1111, 1, 1'b0, 128);
        run_frame(128, 2, -1);

        // Underrun for three frames
        Mode = 2'd0;
        ur_base = ur_cnt[3];
        for (int f = 0; f < 3; f++) begin
            check($sformatf("ur_ready_f%0d", f), {31'd0, rdy[3]}, 32'd1);
            push_frame(16, 32, 2, 128'h0, 0, 1'b0, 64);
            run_frame(64, 3, -1);
        end
        check("ur_three_pulses", ur_cnt[3] - ur_base, 3);
        check("ur_ready_end", {31'd0, rdy[3]}, 32'd1);

        // Short frame, recovery, and an over-long frame that saturates
        Mode = 2'd1;
        fe_base = fe_cnt[3];
        ur_base = ur_cnt[3];
        offer(3, 128'h7E81_C3A5);
        push_frame(16, 32, 2, 128'h7E81_C3A5, 1, 1'b0, 40);
        run_frame(40, 3, -1);
        check("short_no_err_yet", fe_cnt[3] - fe_base, 0);
        offer(3, 128'h6BD2_9F01);
        push_frame(16, 32, 2, 128'h6BD2_9F01, 1, 1'b0, 64);
        run_frame(64, 3, -1);
        check("short_err", fe_cnt[3] - fe_base, 1);
        offer(3, 128'hF00F_0FF1);
        push_frame(16, 32, 2, 128'hF00F_0FF1, 1, 1'b0, 66);
        run_frame(66, 3, -1);
        check("full_no_err", fe_cnt[3] - fe_base, 1);
        offer(3, 128'hAAAA_5555);
        push_frame(16, 32, 2, 128'hAAAA_5555, 1, 1'b0, 64);
        run_frame(64, 3, -1);
        check("sat_no_err", fe_cnt[3] - fe_base, 1);
        check("short_no_underrun", ur_cnt[3] - ur_base, 0);
        check("a_no_frame_err", fe_cnt[0], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
